// File: rtl/uart_pkg.sv
// Shared UART definitions: capture-state encoding and the reset baud divisor.
package uart_pkg;

    // 50 MHz / 27 ~= 115200 baud x16 oversampling.
    localparam int unsigned UART_DEFAULT_DIV = 26;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAck  = 2'd1,
        StWait = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO with occupancy count; a pop on an empty FIFO is ignored.
module uart_byte_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: oversampling tick generator, rdy/rdy_clr handshake
// with the byte receiver, byte FIFO toward the host and sticky overrun flag.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk_50m,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          div_wr,
    input  logic [DIV_W-1:0]              div_in,
    output logic                          clken,
    input  logic                          rx_rdy,
    input  logic [7:0]                    rx_data,
    output logic                          rx_rdy_clr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [7:0]                    m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          ovr_clr
);

    // ---------------- Tick generator ----------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        clken = 1'b0;
        if (div_wr) begin
            // A divisor write restarts the period and suppresses this cycle's tick.
            div_d = div_in;
            cnt_d = '0;
        end else if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == div_q) begin
            clken = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            div_q <= DIV_W'(DEFAULT_DIV);
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- Capture FSM ----------------
    cap_state_e state_q, state_d;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        rx_rdy_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_rdy) begin
                    push    = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                rx_rdy_clr = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                if (!rx_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FIFO ----------------
    assign pop     = m_valid && m_ready;
    assign m_valid = !fifo_empty;

    uart_byte_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk_50m),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i (rx_data),
        .pop_i   (pop),
        .rdata_o (m_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------- Overrun ----------------
    logic ovr_q, ovr_d;
    logic drop;

    assign drop = push && fifo_full && !pop;

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with a simple receiver model.
module tb_uart_rx_ctrl;

    localparam int unsigned DIV_W = 16;

    logic             clk_50m = 1'b0;
    logic             rst;
    logic             en;
    logic             div_wr;
    logic [DIV_W-1:0] div_in;
    logic             clken;
    logic             rx_rdy;
    logic [7:0]       rx_data;
    logic             rx_rdy_clr;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;
    logic [3:0]       fifo_count;
    logic             overrun;
    logic             ovr_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_50m = ~clk_50m;

    uart_rx_ctrl #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (26),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .en         (en),
        .div_wr     (div_wr),
        .div_in     (div_in),
        .clken      (clken),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk_50m);
        #1;
    endtask

    // Receiver model: raise rdy with a byte, drop it the cycle after rdy_clr.
    task automatic deliver(input logic [7:0] b, input logic rdy_in_push, input logic clr_in_push);
        logic seen;
        drive_edge();
        rx_rdy  = 1'b1;
        rx_data = b;
        m_ready = rdy_in_push;
        ovr_clr = clr_in_push;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_edge();
            if (i == 0) begin
                m_ready = 1'b0;
                ovr_clr = 1'b0;
            end
            @(negedge clk_50m);
            if (rx_rdy_clr) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rdy_clr_seen", 32'(seen), 32'd1);
        drive_edge();
        rx_rdy = 1'b0;
        @(negedge clk_50m);
    endtask

    task automatic drain_expect(input logic [7:0] first, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive_edge();
            m_ready = 1'b1;
            @(negedge clk_50m);
            check_eq(tag, 32'(m_data), 32'(first + 8'(i)));
        end
        drive_edge();
        m_ready = 1'b0;
        @(negedge clk_50m);
        check_eq({tag, "_empty"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          first;
        int          last;
        int          npulse;
        logic [11:0] mask;

        rst = 1'b0; en = 1'b0; div_wr = 1'b0; div_in = '0;
        rx_rdy = 1'b0; rx_data = '0; m_ready = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 rst = 1'b1;

        @(negedge clk_50m);
        check_eq("rst_clken",   32'(clken),      32'd0);
        check_eq("rst_rdy_clr", 32'(rx_rdy_clr), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid),    32'd0);
        check_eq("rst_count",   32'(fifo_count), 32'd0);
        check_eq("rst_m_data",  32'(m_data),     32'd0);
        check_eq("rst_overrun", 32'(overrun),    32'd0);

        // Default divisor: pulses on enabled cycle indices 26, 53, 80.
        drive_edge();
        en = 1'b1;
        first = -1; last = -1; npulse = 0;
        for (int i = 0; i < 80; i++) begin
            if (i > 0) drive_edge();
            @(negedge clk_50m);
            if (clken) begin
                if (first < 0) first = i;
                last = i;
                npulse++;
            end
        end
        check_eq("first_tick",  32'(first),  32'd26);
        check_eq("second_tick", 32'(last),   32'd53);
        check_eq("tick_count",  32'(npulse), 32'd2);

        // Write divisor 3 exactly on the cycle a tick would fire.
        drive_edge();
        div_wr = 1'b1;
        div_in = 16'd3;
        @(negedge clk_50m);
        check_eq("clken_on_div_wr", 32'(clken), 32'd0);
        drive_edge();
        div_wr = 1'b0;
        mask = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) drive_edge();
            @(negedge clk_50m);
            mask[k-1] = clken;
        end
        check_eq("div3_ticks", 32'(mask), 32'h888);

        // Single byte 0xA5 with receiver enable off.
        drive_edge();
        en = 1'b0;
        rx_rdy = 1'b1;
        rx_data = 8'hA5;
        @(negedge clk_50m);
        check_eq("a5_clr_T",    32'(rx_rdy_clr), 32'd0);
        check_eq("a5_valid_T",  32'(m_valid),    32'd0);
        check_eq("en0_clken",   32'(clken),      32'd0);
        drive_edge();
        @(negedge clk_50m);
        check_eq("a5_clr_T1",   32'(rx_rdy_clr), 32'd1);
        check_eq("a5_valid_T1", 32'(m_valid),    32'd1);
        check_eq("a5_data_T1",  32'(m_data),     32'hA5);
        check_eq("a5_count_T1", 32'(fifo_count), 32'd1);
        drive_edge();
        rx_rdy = 1'b0;
        @(negedge clk_50m);
        check_eq("a5_clr_T2",   32'(rx_rdy_clr), 32'd0);
        drive_edge();
        m_ready = 1'b1;
        drive_edge();
        m_ready = 1'b0;
        @(negedge clk_50m);
        check_eq("a5_pop_valid", 32'(m_valid),    32'd0);
        check_eq("a5_pop_count", 32'(fifo_count), 32'd0);

        // Nine bytes into eight slots: last one dropped.
        for (int i = 0; i < 9; i++) begin
            deliver(8'(i), 1'b0, 1'b0);
            if (i == 7) begin
                check_eq("fill8_count",   32'(fifo_count), 32'd8);
                check_eq("fill8_overrun", 32'(overrun),    32'd0);
            end
        end
        check_eq("ovf_count",   32'(fifo_count), 32'd8);
        check_eq("ovf_overrun", 32'(overrun),    32'd1);
        drain_expect(8'h00, 8, "drain0");

        drive_edge();
        ovr_clr = 1'b1;
        drive_edge();
        ovr_clr = 1'b0;
        @(negedge clk_50m);
        check_eq("ovr_clr", 32'(overrun), 32'd0);

        // Full FIFO, host pops in the push cycle: byte accepted.
        for (int i = 0; i < 8; i++) deliver(8'h10 + 8'(i), 1'b0, 1'b0);
        deliver(8'h18, 1'b1, 1'b0);
        check_eq("fullpop_count",   32'(fifo_count), 32'd8);
        check_eq("fullpop_overrun", 32'(overrun),    32'd0);
        drain_expect(8'h11, 8, "drain1");

        // Overrun set wins over a simultaneous clear.
        for (int i = 0; i < 8; i++) deliver(8'h20 + 8'(i), 1'b0, 1'b0);
        deliver(8'h28, 1'b0, 1'b0);
        check_eq("ovr_set", 32'(overrun), 32'd1);
        deliver(8'h29, 1'b0, 1'b1);
        check_eq("ovr_set_wins", 32'(overrun),    32'd1);
        check_eq("ovr_set_cnt",  32'(fifo_count), 32'd8);

        // Reset with full FIFO, then with three bytes buffered.
        drive_edge();
        rst = 1'b0;
        drive_edge();
        rst = 1'b1;
        @(negedge clk_50m);
        check_eq("rst2_count",   32'(fifo_count), 32'd0);
        check_eq("rst2_overrun", 32'(overrun),    32'd0);
        for (int i = 0; i < 3; i++) deliver(8'h31 + 8'(i), 1'b0, 1'b0);
        check_eq("three_count", 32'(fifo_count), 32'd3);
        check_eq("three_head",  32'(m_data),     32'h31);
        drive_edge();
        rst = 1'b0;
        drive_edge();
        rst = 1'b1;
        @(negedge clk_50m);
        check_eq("rst3_valid",  32'(m_valid),    32'd0);
        check_eq("rst3_count",  32'(fifo_count), 32'd0);
        check_eq("rst3_m_data", 32'(m_data),     32'd0);

        // Divisor returns to default after reset.
        drive_edge();
        en = 1'b1;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) drive_edge();
            @(negedge clk_50m);
            if (clken && first < 0) first = i;
        end
        check_eq("rst_div_default", 32'(first), 32'd26);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART byte receiver. Generates the receiver's 16x oversampling enable from a programmable divisor, services the receiver's `rdy`/`rdy_clr` handshake, and buffers received bytes in a small FIFO with a valid/ready output toward the host. Latches a sticky overrun flag when a byte arrives while the FIFO is full. Sits between the receiver instance and any bus-facing register block.

## Interface

**Parameters**
- `DIV_W`, 16: divisor register width.
- `DEFAULT_DIV`, 26: divisor after reset. The clken period is `DEFAULT_DIV+1` cycles, so 27 gives ≈115200 baud ×16 at 50 MHz.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of two, ≥2.

**Ports**
- `clk_50m`, in, 1: the single clock.
- `rst`, in, 1: reset; synchronous, active-low.
- `en`, in, 1: receive enable; gates `clken` generation.
- `div_wr`, in, 1: load `div_in` into the divisor register.
- `div_in`, in, DIV_W: new divisor value N; clken period is N+1 cycles.
- `clken`, out, 1: one-cycle oversampling tick to the receiver.
- `rx_rdy`, in, 1: the receiver's `rdy`.
- `rx_data`, in, 8: the receiver's `data`.
- `rx_rdy_clr`, out, 1: drives the receiver's `rdy_clr`.
- `m_valid`, out, 1: FIFO not empty.
- `m_ready`, in, 1: host accepts `m_data`.
- `m_data`, out, 8: head of FIFO (show-ahead).
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `overrun`, out, 1: sticky overrun flag.
- `ovr_clr`, in, 1: clear `overrun`.

## Operation

**Tick generator**
- `div_reg` holds the divisor. `cnt` counts from 0 to `div_reg`.
- When `en`=1 and `cnt==div_reg`: `clken`=1 for that cycle and `cnt` returns to 0.
- `div_reg`=0 gives `clken` on every enabled cycle.
- When `en`=0: `cnt` is held at 0 and `clken`=0.
- `div_wr` loads `div_reg` and zeroes `cnt` in the same cycle. `clken`=0 in that cycle.

**Capture FSM** (states IDLE, ACK, WAIT)
- IDLE: if `rx_rdy`=1, push `rx_data`, or flag overrun if the FIFO is full; then go to ACK.
- ACK: `rx_rdy_clr`=1, decoded from the registered state; go to WAIT.
- WAIT: stay while `rx_rdy`=1; go to IDLE when `rx_rdy`=0.
- The FSM runs regardless of `en`, so a pending byte is still drained.

**FIFO**
- Pop occurs when `m_valid && m_ready`.
- Push while full is dropped and sets `overrun`, except when a pop happens in the same cycle. In that case the push succeeds and `overrun` is not set.
- Simultaneous push and pop on an empty FIFO: push only (`m_valid` was 0, so no pop occurs).
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` is 0..FIFO_DEPTH.
- `m_data` is undefined while `m_valid`=0.

**Overrun**
- Set on a dropped byte.
- Cleared by `ovr_clr`; set wins if both occur in the same cycle.

**Reset** (`rst`=0 at a clock edge)
- `div_reg`=DEFAULT_DIV, `cnt`=0, `clken`=0, state IDLE, `rx_rdy_clr`=0.
- FIFO empty: `m_valid`=0, `fifo_count`=0, `m_data`=0.
- `overrun`=0.
- Reset mid-operation discards buffered bytes. The receiver is not reset by this block; if its `rdy` is still high, the byte is captured after reset releases.

## Timing

- `rx_rdy` rises and is sampled in cycle T:
  - push at edge T, so `m_valid`=1 in T+1;
  - `rx_rdy_clr`=1 in T+1;
  - receiver `rdy` is low in T+2;
  - FSM back in IDLE in T+3.
- Minimum capture turnaround is 3 cycles. A UART frame is ≥160 `clken` periods, so a new `rdy` can never overlap a handshake.
- First `clken` after reset with `en`=1 falls in the cycle with `cnt==div_reg`, i.e. the (DEFAULT_DIV+1)th enabled cycle.
- Pop takes effect at the edge; the next head appears on `m_data` the following cycle.

## Structure

- Package `uart_pkg`: capture-state enum (IDLE/ACK/WAIT) and a `UART_DEFAULT_DIV` constant shared with a future TX controller.
- One natural sub-module: `uart_byte_fifo` (parameterised depth, push/pop/full/empty/count, show-ahead read). The transmit side will reuse it.

## Test plan

- Reset, `en`=1, default divisor → `clken` pulses every 27 cycles; all outputs at their reset values before the first pulse.
- `div_wr` with `div_in`=3 mid-count → `cnt` restarts at 0; `clken` every 4 cycles starting 4 cycles after the write.
- Receiver model raises `rdy` with data 0xA5 → `rx_rdy_clr` high exactly one cycle at T+1; `m_valid`=1, `m_data`=0xA5 at T+1; `fifo_count`=1.
- `m_ready`=0, deliver 9 bytes 0x00..0x08 into an 8-deep FIFO → `fifo_count`=8, `overrun`=1, and 0x08 is dropped. Then drain with `m_ready`=1 → 0x00..0x07 in order.
- FIFO full with `m_ready`=1 in the push cycle → no overrun; `fifo_count` stays 8.
- `ovr_clr` and a new overrun in the same cycle → `overrun` stays 1. Assert `rst`=0 with 3 bytes buffered → `m_valid`=0 and `fifo_count`=0 the next cycle.
